sll_traverser: RTL and testbench

Downstream consumer of the singly linked list block. On a single start pulse it walks the list from head, following next-node pointers. It issues one read operation per node over the list's op/op_start/op_done handshake and streams each node's data out on a valid/ready interface, tagged with its position and a last flag. It turns the list's random-access read port into an ordered in-list-order stream for later stages.

---
 rtl/sll_traverser.sv | 165 ++++++++++++++++
 tb/tb_sll_traverser.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sll_traverser.sv
// sll_traverser: walks a singly linked list from its head, one read per node
// over the list's op/op_start/op_done handshake, and streams each node's data
// out in list order with its 0-based position and a last flag.
// Optional build macro: SLL_TRAV_CYCLE_GUARD_EN adds an abort (error=1) when the
// walk reaches MAX_NODE reads without terminating, or when a next pointer lies
// beyond ADDR_NULL.
module sll_traverser #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            ll_op,
    output logic [ADDR_WIDTH-1:0] ll_addr,
    output logic                  ll_op_start,
    input  logic                  ll_op_done,
    input  logic [DATA_WIDTH-1:0] ll_data_out,
    input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
    input  logic                  ll_fault,
    input  logic [ADDR_WIDTH-1:0] ll_head,
    input  logic [ADDR_WIDTH-1:0] ll_length,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_index,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(MAX_NODE);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  last_q, last_d;
    logic                  error_q, error_d;
    logic                  guard_abort;

`ifdef SLL_TRAV_CYCLE_GUARD_EN
    // A read at position MAX_NODE means the chain never terminated; a pointer
    // past ADDR_NULL cannot address any node.
    assign guard_abort = (count_q == ADDR_NULL) || (ll_next_node_addr > ADDR_NULL);
`else
    assign guard_abort = 1'b0;
`endif

    // State and datapath registers; reset abandons any in-flight read at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cur_q   <= ADDR_NULL;
            nxt_q   <= ADDR_NULL;
            count_q <= '0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            count_q <= count_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
            error_q <= error_d;
        end
    end

    // Next-state logic: snapshot on start, one read per node, hold each beat until taken.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        count_d = count_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = ll_length;
                    cur_d   = ll_head;
                    count_d = '0;
                    error_d = 1'b0;
                    if ((ll_length == '0) || (ll_head == ADDR_NULL)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ll_op_done) begin
                    if (ll_fault || guard_abort) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        data_d  = ll_data_out;
                        nxt_d   = ll_next_node_addr;
                        index_d = count_q;
                        last_d  = (ll_next_node_addr == ADDR_NULL) || ((count_q + ONE) == len_q);
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = nxt_q;
                        count_d = count_q + ONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode from the state so reset clears them immediately.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        error       = (state_q == S_DONE) && error_q;
        ll_op       = 3'd0;
        ll_op_start = (state_q == S_REQ) || (state_q == S_WAIT);
        ll_addr     = ll_op_start ? cur_q : ADDR_NULL;
        m_valid     = (state_q == S_OUT);
        m_data      = data_q;
        m_index     = index_q;
        m_last      = (state_q == S_OUT) && last_q;
    end

endmodule

// File: tb/tb_sll_traverser.sv
// Testbench for sll_traverser: a clocked list responder with random latency,
// an in-order expected-beat model derived from the list contents, and one
// monitor that checks beats, stalls, completion and handshake rules each cycle.
module tb_sll_traverser;
    localparam int DW = 8;
    localparam int MN = 8;
    localparam int AW = 4;
    localparam logic [AW-1:0] NUL = 4'd8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy, done, error;
    logic [2:0]    ll_op;
    logic [AW-1:0] ll_addr;
    logic          ll_op_start;
    logic          ll_op_done;
    logic [DW-1:0] ll_data_out;
    logic [AW-1:0] ll_next_node_addr;
    logic          ll_fault;
    logic [AW-1:0] ll_head, ll_length;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_index;
    logic          m_last;

    sll_traverser #(.DATA_WIDTH(DW), .MAX_NODE(MN)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .ll_op(ll_op), .ll_addr(ll_addr), .ll_op_start(ll_op_start), .ll_op_done(ll_op_done),
        .ll_data_out(ll_data_out), .ll_next_node_addr(ll_next_node_addr), .ll_fault(ll_fault),
        .ll_head(ll_head), .ll_length(ll_length), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_index(m_index), .m_last(m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic          exp_err;
    int            pass_cnt = 0;
    int            tot_cnt  = 0;
    int            cyc = 0;
    logic [DW-1:0] dmem[MN];
    logic [AW-1:0] nmem[MN];
    int            fault_at = 100;
    int            lat = 0;
    int            ready_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tot_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // List responder: op_done one cycle per accepted request after 'lat' extra cycles.
    int lcnt = 0;
    int rd_num = 0;
    always @(posedge clk) begin
        if (!busy) rd_num <= 0;
        if (!ll_op_start) begin
            ll_op_done <= 1'b0;
            lcnt       <= 0;
        end else if (ll_op_done) begin
            ll_op_done <= 1'b0;
        end else if (lcnt >= lat) begin
            ll_op_done        <= 1'b1;
            ll_data_out       <= dmem[ll_addr[2:0]];
            ll_next_node_addr <= nmem[ll_addr[2:0]];
            ll_fault          <= (rd_num == fault_at);
            rd_num            <= rd_num + 1;
            lcnt              <= 0;
        end else begin
            lcnt <= lcnt + 1;
        end
    end

    // Stream sink ready: always, random, or a 5-cycle stall on beat index 1.
    int stall_n = 0;
    always @(posedge clk) begin
        #1;
        if (!busy) stall_n = 0;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                if (m_valid && m_index == 4'd1 && stall_n < 5) begin
                    m_ready = 1'b0;
                    stall_n++;
                end else begin
                    m_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: checks every beat, stall stability, completion and the op_start rule.
    logic          stalled = 1'b0, prev_done = 1'b0, done_seen = 1'b0;
    logic [DW-1:0] sd;
    logic [AW-1:0] si;
    logic          sl;
    int            beats = 0, stall_cycles = 0, first_valid = -1, done_cyc = -1;
    always @(negedge clk) begin
        if (rst) begin
            if (start && !busy) begin
                beats = 0; stall_cycles = 0; first_valid = -1; done_cyc = -1; done_seen = 1'b0;
            end
            if (prev_done) chk("op_start_after_done", 64'(ll_op_start), 64'd0);
            prev_done = ll_op_done;
            if (stalled) begin
                chk("stall_hold", {m_valid, m_data, m_index, m_last, ll_op_start},
                    {1'b1, sd, si, sl, 1'b0});
                stall_cycles++;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {m_data, m_index}, 64'hDEAD);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", {m_data, m_index, m_last, ll_op}, {e.d, e.idx, e.last, 3'd0});
                    beats++;
                end
            end
            stalled = m_valid && !m_ready;
            sd = m_data; si = m_index; sl = m_last;
            if (done) begin
                chk("done_error", {error, 1'(exp_q.size() == 0)}, {exp_err, 1'b1});
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
        end else begin
            stalled   = 1'b0;
            prev_done = 1'b0;
        end
    end

    // Reference: the beats a traversal must produce, walked straight from the list contents.
    task automatic build_model(input logic [AW-1:0] head, input logic [AW-1:0] len, input int flt);
        int cur;
        beat_t b;
        exp_q.delete();
        exp_err = 1'b0;
        cur = int'(head);
        if (len == 0 || head == NUL) return;
        for (int i = 0; i < 64; i++) begin
            if (i == flt) begin exp_err = 1'b1; return; end
`ifdef SLL_TRAV_CYCLE_GUARD_EN
            if (i == MN || nmem[cur] > NUL) begin exp_err = 1'b1; return; end
`endif
            b.d    = dmem[cur];
            b.idx  = 4'(i);
            b.last = (nmem[cur] == NUL) || (i + 1 == int'(len));
            exp_q.push_back(b);
            if (b.last) return;
            cur = int'(nmem[cur]);
        end
    endtask

    int s_cyc = 0;
    int n_exp = 0;
    task automatic run(input logic [AW-1:0] head, input logic [AW-1:0] len, input int flt,
                       input int mode, input int latency, input bit scramble);
        ll_head = head; ll_length = len; fault_at = flt; ready_mode = mode; lat = latency;
        build_model(head, len, flt);
        n_exp = exp_q.size();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
        if (scramble) begin
            ll_head   = 4'($urandom_range(0, 8));
            ll_length = 4'($urandom_range(0, 8));
            start     = 1'b1;
            @(posedge clk); #1;
            start     = 1'b0;
        end
        for (int k = 0; k < 3000 && !done_seen; k++) begin
            @(negedge clk); #1;
        end
        chk("done_seen", 64'(done_seen), 64'd1);
        @(negedge clk); #1;
        chk("beat_count", 64'(beats), 64'(n_exp));
        chk("idle_after", {busy, done}, 2'b00);
    endtask

    task automatic load_abc();
        for (int i = 0; i < MN; i++) begin dmem[i] = 8'h00; nmem[i] = NUL; end
        dmem[0] = 8'h11; nmem[0] = 4'd1;
        dmem[1] = 8'h22; nmem[1] = 4'd2;
        dmem[2] = 8'h33; nmem[2] = NUL;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ll_head = NUL; ll_length = 4'd0; m_ready = 1'b1;
        for (int i = 0; i < MN; i++) begin dmem[i] = 8'h00; nmem[i] = NUL; end
        #2;
        chk("reset_outputs", {busy, done, error, ll_op, ll_addr, ll_op_start, m_valid, m_data, m_index, m_last},
            {1'b0, 1'b0, 1'b0, 3'd0, NUL, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0});
        #20 rst = 1'b1;

        // Three-node list, ready held high; pin the model and the timing.
        load_abc();
        build_model(4'd0, 4'd3, 100);
        chk("model_beat0", {exp_q[0].d, exp_q[0].idx, exp_q[0].last}, {8'h11, 4'd0, 1'b0});
        chk("model_beat1", {exp_q[1].d, exp_q[1].idx, exp_q[1].last}, {8'h22, 4'd1, 1'b0});
        chk("model_beat2", {exp_q[2].d, exp_q[2].idx, exp_q[2].last}, {8'h33, 4'd2, 1'b1});
        run(4'd0, 4'd3, 100, 0, 0, 1'b0);
        chk("abc_first_valid_lat", 64'(first_valid - s_cyc), 64'd2);
        chk("abc_done_lat", 64'(done_cyc - s_cyc), 64'd9);
        $display("txn abc: beats=%0d done_lat=%0d", beats, done_cyc - s_cyc);

        // Empty list.
        run(NUL, 4'd0, 100, 0, 0, 1'b0);
        chk("empty_done_lat", 64'(done_cyc - s_cyc), 64'd0);
        chk("empty_no_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
        $display("txn empty: beats=%0d", beats);

        // Stall of 5 cycles on beat 1.
        run(4'd0, 4'd3, 100, 2, 1, 1'b0);
        chk("stall_count", 64'(stall_cycles), 64'd5);
        $display("txn stall: beats=%0d stall_cycles=%0d", beats, stall_cycles);

        // Fault on the second read.
        run(4'd0, 4'd3, 1, 0, 1, 1'b0);
        chk("fault_beats", 64'(beats), 64'd1);
        $display("txn fault: beats=%0d", beats);

        // Reset while waiting on the list.
        ll_head = 4'd0; ll_length = 4'd3; lat = 6; ready_mode = 0; fault_at = 100;
        exp_q.delete(); exp_err = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("in_wait", {ll_op_start, busy, ll_addr}, {1'b1, 1'b1, 4'd0});
        rst = 1'b0; #1;
        chk("rst_midflight", {ll_op_start, busy, m_valid, done, error, ll_addr, m_last},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NUL, 1'b0});
        #2 rst = 1'b1;
        $display("txn reset_in_wait");
        run(4'd0, 4'd3, 100, 0, 0, 1'b0);
        $display("txn after_reset: beats=%0d", beats);

`ifdef SLL_TRAV_CYCLE_GUARD_EN
        // Cyclic chain 0 -> 1 -> 0 with a length that never ends the walk.
        for (int i = 0; i < MN; i++) begin dmem[i] = 8'(8'hA0 + i); nmem[i] = NUL; end
        nmem[0] = 4'd1; nmem[1] = 4'd0;
        run(4'd0, 4'd15, 100, 0, 0, 1'b0);
        chk("guard_beats", 64'(beats), 64'd8);
        $display("txn guard_cycle: beats=%0d", beats);
`endif

        // Randomized lists, latency, ready and mid-run input changes.
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] h, l;
            int f;
            for (int i = 0; i < MN; i++) begin
                dmem[i] = 8'($urandom);
                nmem[i] = 4'($urandom_range(0, 8));
            end
            h = 4'($urandom_range(0, 8));
            l = 4'($urandom_range(0, 8));
            f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 100;
            run(h, l, f, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);
            $display("txn rand %0d: head=%0d len=%0d fault_at=%0d beats=%0d", t, h, l, f, beats);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
